// File: rtl/pc_16.sv
// Hack-style program counter: a clear/load/increment/hold select chain feeding a WIDTH-bit
// register, plus a one-cycle wrap flag raised when an increment rolls over from all-ones.
module pc_16 #(
    parameter int unsigned          WIDTH     = 16,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] inc_val, sel_inc, sel_load;
    logic             wrap_q, wrap_d;
    logic             all_ones;

    // Same per-bit 2:1 select as the upstream mux primitive: sel ? b : a.
    function automatic logic [WIDTH-1:0] mux2(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             sel);
        return sel ? b : a;
    endfunction

    always_comb begin
        all_ones = &count_q;
        inc_val  = count_q + One;
        // Later stages override earlier ones: clr > load > inc > hold.
        sel_inc  = mux2(count_q, inc_val, inc);
        sel_load = mux2(sel_inc, in, load);
        count_d  = mux2(sel_load, RESET_VAL, clr);
        wrap_d   = inc & ~load & ~clr & all_ones;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out  = count_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_pc_16.sv
// Self-checking bench for pc_16: directed scenarios plus randomized control traffic checked
// against a plain arithmetic model of the counter.
module tb_pc_16;

    localparam int unsigned W = 16;
    localparam int unsigned MODV = 65536;

    logic          clk;
    logic          rst;
    logic [W-1:0]  in;
    logic          load;
    logic          inc;
    logic          clr;
    logic [W-1:0]  out;
    logic          wrap;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int unsigned m_out;
    bit          m_wrap;

    pc_16 #(
        .WIDTH     (W),
        .RESET_VAL ('0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .load (load),
        .inc  (inc),
        .clr  (clr),
        .out  (out),
        .wrap (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of controls over one rising edge and advance the model.
    task automatic step(input logic ld, input logic ic, input logic cl, input logic [W-1:0] val);
        int unsigned n;
        bit          nw;
        load = ld;
        inc  = ic;
        clr  = cl;
        in   = val;
        nw   = 1'b0;
        if (cl)      n = 0;
        else if (ld) n = int'(val);
        else if (ic) begin
            n  = (m_out + 1) % MODV;
            nw = (m_out == MODV - 1);
        end else     n = m_out;
        @(posedge clk);
        #1;
        m_out  = n;
        m_wrap = nw;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 0; inc = 0; clr = 0; in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out !== 16'h0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: out=%h wrap=%b, need out=0000 wrap=0", out, wrap);
        end
        rst = 1'b0;
        m_out = 0; m_wrap = 0;
        step(1, 0, 0, 16'h1234);
        checks++;
        if (out !== 16'h1234) begin
            errors++;
            $display("FAIL reset_preload: out=%h, need 1234", out);
        end
        // Assert between edges; outputs must clear before the next edge.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out=%h wrap=%b, need out=0000 wrap=0", out, wrap);
        end
        inc = 1'b1; load = 1'b1; in = 16'h5555;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out !== 16'h0000 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold%0d: out=%h wrap=%b, need out=0000 wrap=0", i, out, wrap);
            end
        end
        rst = 1'b0; inc = 0; load = 0;
        m_out = 0; m_wrap = 0;
    endtask

    task automatic test_increment();
        for (int i = 1; i <= 3; i++) begin
            step(0, 1, 0, 16'hBEEF);
            checks++;
            if (out !== 16'(i)) begin
                errors++;
                $display("FAIL inc_%0d: out=%h, need %h", i, out, 16'(i));
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 16'hBEEF);
            checks++;
            if (out !== 16'h0003 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: out=%h wrap=%b, need out=0003 wrap=0", i, out, wrap);
            end
        end
    endtask

    task automatic test_load_priority();
        step(1, 1, 0, 16'h00FF);
        checks++;
        if (out !== 16'h00FF) begin
            errors++;
            $display("FAIL load_over_inc: out=%h, need 00ff", out);
        end
        step(0, 1, 0, 16'h00FF);
        checks++;
        if (out !== 16'h0100) begin
            errors++;
            $display("FAIL inc_after_load: out=%h, need 0100", out);
        end
    endtask

    task automatic test_clear_priority();
        step(1, 1, 1, 16'hAAAA);
        checks++;
        if (out !== 16'h0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL clr_over_all: out=%h wrap=%b, need out=0000 wrap=0", out, wrap);
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 16'hFFFF);
        step(0, 1, 0, 16'h0000);
        checks++;
        if (out !== 16'h0000 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL wrap_set: out=%h wrap=%b, need out=0000 wrap=1", out, wrap);
        end
        step(0, 1, 0, 16'h0000);
        checks++;
        if (out !== 16'h0001 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_clear: out=%h wrap=%b, need out=0001 wrap=0", out, wrap);
        end
        step(1, 1, 0, 16'hFFFF);
        checks++;
        if (out !== 16'hFFFF || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_ones: out=%h wrap=%b, need out=ffff wrap=0", out, wrap);
        end
        // Increment from all-ones overridden by load must not flag a wrap.
        step(1, 1, 0, 16'h0042);
        checks++;
        if (out !== 16'h0042 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_load_override: out=%h wrap=%b, need out=0042 wrap=0", out, wrap);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 16'h0005);
        inc = 1'b1; load = 1'b0; clr = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: out=%h wrap=%b, need out=0000 wrap=0", out, wrap);
        end
        #4 rst = 1'b0;
        m_out = 0; m_wrap = 0;
        step(0, 1, 0, 16'h0000);
        checks++;
        if (out !== 16'h0001) begin
            errors++;
            $display("FAIL reset_release_inc: out=%h, need 0001", out);
        end
    endtask

    task automatic test_random();
        logic         cl, ld, ic;
        logic [W-1:0] val;
        int unsigned  r;
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99);
            cl = (r < 5);
            ld = (r >= 5 && r < 25);
            ic = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       val = 16'hFFFF;
                1:       val = 16'hFFFE;
                default: val = 16'($urandom);
            endcase
            step(ld, ic, cl, val);
            checks++;
            if (out !== 16'(m_out) || wrap !== m_wrap) begin
                errors++;
                $display("FAIL rand_%0d: out=%h wrap=%b, need out=%h wrap=%b",
                         i, out, wrap, 16'(m_out), m_wrap);
            end
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if (out !== 16'h0000 || wrap !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_rst_%0d: out=%h wrap=%b, need out=0000 wrap=0",
                             i, out, wrap);
                end
                #1 rst = 1'b0;
                m_out = 0; m_wrap = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 0; inc = 0; clr = 0; in = '0;
        m_out = 0; m_wrap = 0;
        test_reset();
        test_increment();
        test_load_priority();
        test_clear_priority();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
